// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults, FSM encoding and grant-index sizing for the register file write-port controller.
package regfile_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single requester still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
// Latency 0; grants nothing when disabled, no state of its own.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between round-robin requesters and an init sweep (reg i = i).
// Write lands one cycle after handshake; requesters stall (ready=0) during the sweep.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      init_start_i,
  output logic                      init_busy_o,
  output logic                      init_done_o,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic [IDX_W-1:0]          grant_id_o
);

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [IDX_W-1:0]    grant_id_q;

  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                hs;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // init_start pre-empts arbitration in the same cycle it arrives.
  assign arb_en = reset_ni && (state_q == ST_IDLE) && !init_start_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign hs       = |(req_valid_i & gnt);
  assign sel_addr = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data_i[gnt_idx*DATA_W +: DATA_W];
  assign ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= ADDR_W'(1);
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_start_i) begin
            state_q <= ST_INIT;
            wr_en_q <= 1'b0;
          end else if (hs) begin
            ptr_q      <= ptr_d;
            grant_id_q <= gnt_idx;
            // r0 is hardwired: accept the request but never strobe the port.
            wr_en_q    <= (sel_addr != '0);
            wr_addr_q  <= sel_addr;
            wr_data_q  <= sel_data;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        ST_INIT: begin
          // cnt wraps to 0 only after the top address has been written.
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            wr_en_q <= 1'b0;
            cnt_q   <= ADDR_W'(1);
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= DATA_W'(cnt_q);
            cnt_q     <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = gnt;
  assign init_busy_o = (state_q == ST_INIT);
  assign init_done_o = (state_q == ST_DONE);
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter (3 requesters, 32-bit data, 5-bit address).
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   vld;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]   rdy;
  logic            init_start;
  logic            busy;
  logic            done;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   gid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .req_valid_i  (vld),
    .req_addr_i   (addr),
    .req_data_i   (data),
    .req_ready_o  (rdy),
    .init_start_i (init_start),
    .init_busy_o  (busy),
    .init_done_o  (done),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .grant_id_o   (gid)
  );

  typedef struct {
    logic [2:0] v;
    logic [4:0] a0, a1, a2;
    logic [2:0] rdy;
    logic [1:0] gid;
    logic       en;
    logic [4:0] wa;
    logic       chk_a;
  } vec_t;

  vec_t vt[13];

  function automatic logic [31:0] dval(input int i, input logic [4:0] a);
    if (a == 5'd0) return 32'hDEADBEEF;
    return 32'hC0DE0000 | (32'(i) << 8) | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2);
    vld  = v;
    addr = {a2, a1, a0};
    data = {dval(2, a2), dval(1, a1), dval(0, a0)};
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Arbitration vectors from a fresh reset (ptr = 0).
    vt[0]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b001, 2'd0, 1'b1, 5'd5, 1'b1};
    vt[1]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b010, 2'd1, 1'b1, 5'd6, 1'b1};
    vt[2]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b100, 2'd2, 1'b1, 5'd7, 1'b1};
    vt[3]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b001, 2'd0, 1'b1, 5'd5, 1'b1};
    vt[4]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b010, 2'd1, 1'b1, 5'd6, 1'b1};
    vt[5]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b100, 2'd2, 1'b1, 5'd7, 1'b1};
    vt[6]  = '{3'b000, 5'd5, 5'd6, 5'd7, 3'b000, 2'd2, 1'b0, 5'd7, 1'b1};
    vt[7]  = '{3'b100, 5'd1, 5'd2, 5'd9, 3'b100, 2'd2, 1'b1, 5'd9, 1'b1};
    vt[8]  = '{3'b100, 5'd1, 5'd2, 5'd10, 3'b100, 2'd2, 1'b1, 5'd10, 1'b1};
    vt[9]  = '{3'b011, 5'd5, 5'd6, 5'd7, 3'b001, 2'd0, 1'b1, 5'd5, 1'b1};
    vt[10] = '{3'b010, 5'd5, 5'd0, 5'd7, 3'b010, 2'd1, 1'b0, 5'd0, 1'b0};
    vt[11] = '{3'b011, 5'd5, 5'd6, 5'd7, 3'b001, 2'd0, 1'b1, 5'd5, 1'b1};
    vt[12] = '{3'b110, 5'd5, 5'd6, 5'd7, 3'b010, 2'd1, 1'b1, 5'd6, 1'b1};

    rst_n      = 1'b0;
    init_start = 1'b0;
    drive(3'b111, 5'd5, 5'd6, 5'd7);

    // Reset hold with every requester valid.
    tick();
    tick();
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_gid", 32'(gid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].a0, vt[i].a1, vt[i].a2);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(vt[i].rdy));
      tick();
      chk($sformatf("v%0d_gid", i), 32'(gid), 32'(vt[i].gid));
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vt[i].en));
      if (vt[i].chk_a) begin
        chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vt[i].wa));
        chk($sformatf("v%0d_wr_data", i), wr_data, dval(int'(vt[i].gid), vt[i].wa));
      end
    end

    // Init sweep colliding with requester 2; a stray init_start mid-sweep is ignored.
    drive(3'b100, 5'd1, 5'd2, 5'd9);
    init_start = 1'b1;
    #1;
    chk("collide_ready", 32'(rdy), 32'd0);
    tick();
    init_start = 1'b0;
    chk("init_busy_rise", 32'(busy), 32'd1);
    chk("init_first_idle_wr", 32'(wr_en), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      init_start = (k == 5);
      #1;
      chk($sformatf("init%0d_ready", k), 32'(rdy), 32'd0);
      tick();
      chk($sformatf("init%0d_wr_en", k), 32'(wr_en), 32'd1);
      chk($sformatf("init%0d_wr_addr", k), 32'(wr_addr), 32'(k));
      chk($sformatf("init%0d_wr_data", k), wr_data, 32'(k));
      chk($sformatf("init%0d_done", k), 32'(done), 32'd0);
      chk($sformatf("init%0d_busy", k), 32'(busy), 32'd1);
    end
    init_start = 1'b0;
    #1;
    chk("init_tail_ready", 32'(rdy), 32'd0);
    tick();
    chk("init_done_pulse", 32'(done), 32'd1);
    chk("init_busy_fall", 32'(busy), 32'd0);
    chk("init_done_wr_en", 32'(wr_en), 32'd0);
    chk("done_ready", 32'(rdy), 32'd0);
    tick();
    chk("done_clears", 32'(done), 32'd0);
    chk("post_done_ready", 32'(rdy), 32'b100);
    tick();
    chk("post_done_gid", 32'(gid), 32'd2);
    chk("post_done_wr_en", 32'(wr_en), 32'd1);
    chk("post_done_wr_addr", 32'(wr_addr), 32'd9);
    chk("post_done_wr_data", wr_data, dval(2, 5'd9));
    drive(3'b000, 5'd0, 5'd0, 5'd0);
    tick();
    chk("quiet_wr_en", 32'(wr_en), 32'd0);

    // Reset partway through a sweep, then a fresh sweep restarts from address 1.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_wr_addr", 32'(wr_addr), 32'd10);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_no_done%0d", k), 32'(done | busy), 32'd0);
    end
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    chk("restart_wr_addr", 32'(wr_addr), 32'd1);
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    tick();
    chk("restart_wr_addr2", 32'(wr_addr), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between several writeback requesters using round-robin arbitration with a valid/ready handshake. Also contains an init sequencer that rewrites every register to its power-on value (register *i* = *i*) through the same port, replacing a bulk reset inside the register file. Sits between the writeback sources (ALU, load unit, debug port) and the register file's write-enable, write-address and write-data inputs.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, register width
- ADDR_W, 5, register address width (2^ADDR_W registers)

- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero grant, combinational
- init_start  in  1  one-cycle pulse that starts the register init sweep
- init_busy  out  1  sweep in progress
- init_done  out  1  one-cycle pulse when the sweep completes
- wr_en  out  1  drives the register file write enable
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  DATA_W  register file write data
- grant_id  out  clog2(NUM_REQ)  index of the last accepted requester, registered

## Operation
- FSM states:
  - IDLE: arbitrates requesters.
  - INIT: sweeps addresses.
  - DONE: one cycle; asserts init_done, then returns to IDLE.
- IDLE → INIT on init_start. INIT → DONE when the counter has emitted address 2^ADDR_W−1.
- Arbitration:
  - Active only in IDLE with init_start low.
  - Round-robin pointer ptr: search from ptr upward with wrap; the first valid requester gets req_ready.
  - On handshake (valid & ready), ptr ← granted index + 1, wrapping to 0 after NUM_REQ−1.
  - Requesters hold valid, addr and data until ready.
- Address 0:
  - A request to address 0 is accepted normally: ready, ptr advances, grant_id updates.
  - wr_en stays 0 for that write, because r0 is hardwired.
- INIT sweep:
  - Counter runs from 1 to 2^ADDR_W−1; each cycle drives wr_en=1, wr_addr=cnt, wr_data=zero-extended cnt.
  - Address 0 is skipped.
  - All req_ready are 0 during INIT and DONE.
- init_start is ignored while in INIT or DONE.
- init_start in the same cycle as valid requests: init wins and no requester is accepted that cycle.

## Timing
- Reset (reset=0 at posedge) forces:
  - state=IDLE, ptr=0, cnt=1
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0
  - init_busy=0, init_done=0
  - req_ready evaluates to 0 while reset is low.
- Request latency: handshake at edge N drives wr_en/wr_addr/wr_data from edge N, valid during cycle N+1. With no handshake, wr_en=0 and addr/data hold.
- Throughput: one write per cycle. A single continuously valid requester is accepted every cycle.
- INIT:
  - init_start sampled at edge N → init_busy=1 from N.
  - First write (addr 1) visible in cycle N+1; last write (addr 31 for ADDR_W=5) in cycle N+31.
  - init_busy falls and init_done pulses at edge N+32; arbitration resumes in the cycle after.
- Reset mid-INIT aborts the sweep immediately; no init_done pulse.

## Structure
- Shared package regfile_ctrl_pkg holds:
  - DATA_W and ADDR_W defaults
  - state encoding IDLE/INIT/DONE
  - the function that computes the grant-index width
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant and encoded index
  - purely combinational; the top level owns the ptr register.

## Test plan
- Reset hold: reset=0 with all req_valid=1 → req_ready=0, wr_en=0. Release: requester 0 granted first, wr_addr = req_addr[0] one cycle later.
- Fairness: all 3 valid continuously with addrs 5/6/7 → grants 0,1,2,0,1,2; wr_addr sequence 5,6,7,5,6,7; wr_en high every cycle.
- Address-0 drop: requester 1 writes addr 0 data 0xDEADBEEF → ready=1, grant_id=1, wr_en=0 next cycle, ptr advances to 2.
- Init sweep: init_start pulse → 31 consecutive writes, addr=data=1..31. init_done pulses once at cycle 32; concurrent req_valid held stalls with ready=0 until after DONE.
- Collision: init_start and req_valid[2] in the same cycle → no grant that cycle; requester 2 is accepted in the first IDLE cycle after init_done.
- Mid-sweep reset: reset=0 at sweep cycle 10 → wr_en=0 and init_busy=0 the next cycle, no init_done. A new init_start afterward restarts from addr 1.
